// File: rtl/mm_arb_pkg.sv
// mm_arbiter shared types: master ids and default pending-read depth.
// Imported by mm_id_fifo and mm_arbiter.
package mm_arb_pkg;

  typedef logic master_id_t;

  localparam master_id_t M_JTAG = 1'b0;
  localparam master_id_t M_CPU  = 1'b1;

  localparam int DEFAULT_MAX_PEND = 4;

endpackage

// File: rtl/mm_id_fifo.sv
// Small synchronous FIFO holding the issuing master of each pending read.
// Push on full and pop on empty are ignored.
module mm_id_fifo
  import mm_arb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_MAX_PEND,
  parameter int WIDTH = 1,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mm_arbiter.sv
// Two-master Avalon-MM arbiter: round-robin grant, locked during stalls,
// in-order read response steering. ARB_FIXED_PRIO_EN: m0 wins every tie.
module mm_arbiter
  import mm_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_PEND = DEFAULT_MAX_PEND,
  localparam int BE_W = DATA_W / 8,
  localparam int CW   = $clog2(MAX_PEND) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_waitrequest,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_waitrequest,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] s_address,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  output logic              s_read,
  output logic              s_write,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_waitrequest,
  input  logic              s_readdatavalid,
  output logic              rsp_err
);

  logic       alive;
  logic       lock;
  master_id_t locked_id;
  master_id_t last;
  master_id_t grant;
  master_id_t head;
  logic       req0;
  logic       req1;
  logic       idle;
  logic       g_read;
  logic       g_write;
  logic       full;
  logic       empty;
  logic [CW-1:0] count;
  logic       cmd;
  logic       acc;
  logic       rvalid;
  logic       pop;
  logic       push;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  assign idle = ~(req0 | req1);

  always_comb begin
    grant = last;
    if (lock) begin
      grant = locked_id;
    end else if (req0 & ~req1) begin
      grant = M_JTAG;
    end else if (~req0 & req1) begin
      grant = M_CPU;
    end else if (req0 & req1) begin
`ifdef ARB_FIXED_PRIO_EN
      grant = M_JTAG;
`else
      grant = ~last;
`endif
    end
  end

  assign g_read  = (grant == M_CPU) ? m1_read  : m0_read;
  assign g_write = (grant == M_CPU) ? m1_write : m0_write;

  assign s_address    = (grant == M_CPU) ? m1_address    : m0_address;
  assign s_writedata  = (grant == M_CPU) ? m1_writedata  : m0_writedata;
  assign s_byteenable = (grant == M_CPU) ? m1_byteenable : m0_byteenable;

  // Reads stall at full even if a pop lands this cycle, keeping
  // s_readdatavalid off the waitrequest path.
  assign s_read  = alive & g_read & ~full;
  assign s_write = alive & g_write;

  assign m0_waitrequest = ~alive | (idle ? s_waitrequest :
    ((grant != M_JTAG) | s_waitrequest | (m0_read & full)));
  assign m1_waitrequest = ~alive | (idle ? s_waitrequest :
    ((grant != M_CPU) | s_waitrequest | (m1_read & full)));

  assign cmd    = s_read | s_write;
  assign acc    = cmd & ~s_waitrequest;
  assign push   = acc & s_read;
  assign rvalid = alive & s_readdatavalid;
  assign pop    = rvalid & ~empty;

  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = pop & (head == M_JTAG);
  assign m1_readdatavalid = pop & (head == M_CPU);

  mm_id_fifo #(
    .DEPTH (MAX_PEND),
    .WIDTH (1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (grant),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive     <= 1'b0;
      lock      <= 1'b0;
      locked_id <= M_JTAG;
      last      <= M_CPU;
      rsp_err   <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (acc) begin
        last <= grant;
        lock <= 1'b0;
      end else if (cmd & s_waitrequest) begin
        lock      <= 1'b1;
        locked_id <= grant;
      end
      if (rvalid & empty) begin
        rsp_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mm_arbiter.sv
// Directed vector bench for mm_arbiter (round-robin build).
// Table rows run back to back; state carries from one row to the next.
module tb_mm_arbiter;

  localparam logic [31:0] A0 = 32'h0000_000C;
  localparam logic [31:0] A1 = 32'h0000_0020;
  localparam logic [31:0] W0 = 32'h1234_5678;
  localparam logic [31:0] W1 = 32'hCAFE_F00D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m0_address = A0;
  logic        m0_read = 1'b0;
  logic        m0_write = 1'b0;
  logic [31:0] m0_writedata = W0;
  logic [3:0]  m0_byteenable = 4'hF;
  logic [31:0] m0_readdata;
  logic        m0_waitrequest;
  logic        m0_readdatavalid;
  logic [31:0] m1_address = A1;
  logic        m1_read = 1'b0;
  logic        m1_write = 1'b0;
  logic [31:0] m1_writedata = W1;
  logic [3:0]  m1_byteenable = 4'h3;
  logic [31:0] m1_readdata;
  logic        m1_waitrequest;
  logic        m1_readdatavalid;
  logic [31:0] s_address;
  logic [31:0] s_writedata;
  logic [3:0]  s_byteenable;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_readdata = '0;
  logic        s_waitrequest = 1'b0;
  logic        s_readdatavalid = 1'b0;
  logic        rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mm_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .m0_address       (m0_address),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_byteenable    (m0_byteenable),
    .m0_readdata      (m0_readdata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_byteenable    (m1_byteenable),
    .m1_readdata      (m1_readdata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdatavalid (m1_readdatavalid),
    .s_address        (s_address),
    .s_writedata      (s_writedata),
    .s_byteenable     (s_byteenable),
    .s_read           (s_read),
    .s_write          (s_write),
    .s_readdata       (s_readdata),
    .s_waitrequest    (s_waitrequest),
    .s_readdatavalid  (s_readdatavalid),
    .rsp_err          (rsp_err)
  );

  typedef struct {
    logic        m0r, m0w, m1r, m1w, sw, rdv;
    logic [31:0] rdata;
    logic        esr, esw;
    logic [31:0] eaddr;
    logic        ew0, ew1, ev0, ev1, eerr;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    m0_read = v.m0r; m0_write = v.m0w;
    m1_read = v.m1r; m1_write = v.m1w;
    s_waitrequest = v.sw;
    s_readdatavalid = v.rdv;
    s_readdata = v.rdata;
    #1;
    chk({tag, ".s_read"}, 32'(s_read), 32'(v.esr));
    chk({tag, ".s_write"}, 32'(s_write), 32'(v.esw));
    if (v.esr | v.esw)
      chk({tag, ".s_address"}, s_address, v.eaddr);
    if (v.esw)
      chk({tag, ".s_writedata"}, s_writedata, (v.eaddr == A0) ? W0 : W1);
    if (v.esw)
      chk({tag, ".s_byteenable"}, 32'(s_byteenable),
          (v.eaddr == A0) ? 32'hF : 32'h3);
    chk({tag, ".m0_wait"}, 32'(m0_waitrequest), 32'(v.ew0));
    chk({tag, ".m1_wait"}, 32'(m1_waitrequest), 32'(v.ew1));
    chk({tag, ".m0_rdv"}, 32'(m0_readdatavalid), 32'(v.ev0));
    chk({tag, ".m1_rdv"}, 32'(m1_readdatavalid), 32'(v.ev1));
    chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(v.eerr));
    if (v.ev0) chk({tag, ".m0_rdata"}, m0_readdata, v.rdata);
    if (v.ev1) chk({tag, ".m1_rdata"}, m1_readdata, v.rdata);
  endtask

  initial begin
    // m0r m0w m1r m1w sw rdv rdata | esr esw eaddr ew0 ew1 ev0 ev1 err
    tbl[0]  = '{0,0,0,0,0,0,32'h0,  0,0,32'h0, 0,0,0,0,0};
    tbl[1]  = '{0,1,0,0,0,0,32'h0,  0,1,A0,    0,1,0,0,0};
    tbl[2]  = '{1,0,1,0,0,0,32'h0,  1,0,A1,    1,0,0,0,0};
    tbl[3]  = '{1,0,1,0,0,0,32'h0,  1,0,A0,    0,1,0,0,0};
    tbl[4]  = '{1,0,1,0,0,0,32'h0,  1,0,A1,    1,0,0,0,0};
    tbl[5]  = '{1,0,1,0,0,0,32'h0,  1,0,A0,    0,1,0,0,0};
    tbl[6]  = '{1,0,0,0,0,1,32'hA,  0,0,32'h0, 1,1,0,1,0};
    tbl[7]  = '{1,0,0,0,0,1,32'hB,  1,0,A0,    0,1,1,0,0};
    tbl[8]  = '{0,0,0,0,0,1,32'hC,  0,0,32'h0, 0,0,0,1,0};
    tbl[9]  = '{0,0,0,1,0,1,32'hD,  0,1,A1,    1,0,1,0,0};
    tbl[10] = '{0,0,0,0,0,1,32'hE,  0,0,32'h0, 0,0,1,0,0};
    tbl[11] = '{0,0,0,0,0,1,32'hF,  0,0,32'h0, 0,0,0,0,0};
    tbl[12] = '{0,0,0,0,0,0,32'h0,  0,0,32'h0, 0,0,0,0,1};
    tbl[13] = '{0,1,0,0,0,0,32'h0,  0,1,A0,    0,1,0,0,1};
    tbl[14] = '{0,1,0,1,1,0,32'h0,  0,1,A1,    1,1,0,0,1};
    tbl[15] = '{0,1,0,1,1,0,32'h0,  0,1,A1,    1,1,0,0,1};
    tbl[16] = '{0,1,0,1,1,0,32'h0,  0,1,A1,    1,1,0,0,1};
    tbl[17] = '{0,1,0,1,0,0,32'h0,  0,1,A1,    1,0,0,0,1};
    tbl[18] = '{0,1,0,1,0,0,32'h0,  0,1,A0,    0,1,0,0,1};
    tbl[19] = '{0,0,0,0,1,0,32'h0,  0,0,32'h0, 1,1,0,0,1};

    // Reset state, with requests present to prove they are blocked
    m0_read = 1'b1;
    m1_write = 1'b1;
    @(negedge clk);
    #1;
    chk("rst.s_read", 32'(s_read), 32'h0);
    chk("rst.s_write", 32'(s_write), 32'h0);
    chk("rst.m0_wait", 32'(m0_waitrequest), 32'h1);
    chk("rst.m1_wait", 32'(m1_waitrequest), 32'h1);
    chk("rst.rsp_err", 32'(rsp_err), 32'h0);
    @(negedge clk);
    m0_read = 1'b0;
    m1_write = 1'b0;
    rst = 1'b0;
    #1;
    chk("prealive.m0_wait", 32'(m0_waitrequest), 32'h1);
    chk("prealive.m1_wait", 32'(m1_waitrequest), 32'h1);

    for (int i = 0; i < 20; i++) begin
      apply(tbl[i], $sformatf("v%0d", i));
    end

    // Reset with two reads pending
    apply('{1,0,0,0,0,0,32'h0, 1,0,A0,    0,1,0,0,1}, "r1");
    apply('{0,0,1,0,0,0,32'h0, 1,0,A1,    1,0,0,0,1}, "r2");
    @(negedge clk);
    rst = 1'b1;
    m0_read = 1'b1;
    m1_read = 1'b1;
    #1;
    chk("rmid.s_read", 32'(s_read), 32'h0);
    chk("rmid.m0_wait", 32'(m0_waitrequest), 32'h1);
    chk("rmid.m1_wait", 32'(m1_waitrequest), 32'h1);
    chk("rmid.rsp_err", 32'(rsp_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    s_readdatavalid = 1'b1;
    s_readdata = 32'h77;
    #1;
    chk("rrel.m0_wait", 32'(m0_waitrequest), 32'h1);
    chk("rrel.m1_wait", 32'(m1_waitrequest), 32'h1);
    chk("rrel.m0_rdv", 32'(m0_readdatavalid), 32'h0);
    chk("rrel.m1_rdv", 32'(m1_readdatavalid), 32'h0);
    chk("rrel.s_read", 32'(s_read), 32'h0);
    apply('{1,0,1,0,0,0,32'h0,  1,0,A0,    0,1,0,0,0}, "r3");
    apply('{0,0,0,0,0,1,32'h55, 0,0,32'h0, 0,0,1,0,0}, "r4");
    apply('{0,0,0,0,0,1,32'h66, 0,0,32'h0, 0,0,0,0,0}, "r5");
    apply('{0,0,0,0,0,0,32'h0,  0,0,32'h0, 0,0,0,0,1}, "r6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
